// File: rtl/countdown_timer_ctrl.sv
// mm:ss countdown sequencer for the seven-segment time display.
// Four registered BCD digits decremented once per prescaled one-second tick.
module countdown_timer_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int WARN_SEC = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       warning,
  output logic       expired,
  output logic       timeout
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [6:0]    min_sat;
  logic [6:0]    sec_sat;
  logic [3:0]    d_mt, d_mo, d_st, d_so;
  logic          zero;
  logic          last_sec;
  logic [6:0]    sec_val;

  function automatic logic [6:0] sat_min(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [6:0] sat_sec(input logic [5:0] v);
    return (v > 6'd59) ? 7'd59 : {1'b0, v};
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [6:0] v);
    logic [6:0] q;
    q = v / 7'd10;
    return q[3:0];
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [6:0] v);
    logic [6:0] r;
    r = v % 7'd10;
    return r[3:0];
  endfunction

  assign min_sat  = sat_min(load_min);
  assign sec_sat  = sat_sec(load_sec);
  assign zero     = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign last_sec = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd1);
  assign sec_val  = ({3'b000, sec_tens} * 7'd10) + {3'b000, sec_ones};

  assign running = (state == RUNNING);
  assign expired = (state == EXPIRED);
  assign warning = (state == RUNNING) && (min_tens == 4'd0) && (min_ones == 4'd0) &&
                   (sec_val <= 7'(WARN_SEC));

  // Borrow chain: each digit wraps to its maximum and borrows from the next.
  always_comb begin
    d_mt = min_tens;
    d_mo = min_ones;
    d_st = sec_tens;
    d_so = sec_ones;
    if (sec_ones != 4'd0) begin
      d_so = sec_ones - 4'd1;
    end else begin
      d_so = 4'd9;
      if (sec_tens != 4'd0) begin
        d_st = sec_tens - 4'd1;
      end else begin
        d_st = 4'd5;
        if (min_ones != 4'd0) begin
          d_mo = min_ones - 4'd1;
        end else begin
          d_mo = 4'd9;
          d_mt = min_tens - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (load) begin
        state    <= IDLE;
        presc    <= '0;
        min_tens <= bcd_tens(min_sat);
        min_ones <= bcd_ones(min_sat);
        sec_tens <= bcd_tens(sec_sat);
        sec_ones <= bcd_ones(sec_sat);
      end else if (pause && state == RUNNING) begin
        state <= PAUSED;
      end else if (start && (state == IDLE || state == PAUSED) && !zero) begin
        // Resuming from PAUSED keeps the partial second already counted.
        if (state == IDLE) presc <= '0;
        state <= RUNNING;
      end else if (state == RUNNING) begin
        if (presc == PRESC_MAX) begin
          presc <= '0;
          if (!zero) begin
            min_tens <= d_mt;
            min_ones <= d_mo;
            sec_tens <= d_st;
            sec_ones <= d_so;
            if (last_sec) begin
              state   <= EXPIRED;
              timeout <= 1'b1;
            end
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule
